// File: rtl/seg7_readback_decoder.sv
// Reconstructs hex value, decimal point and validity per digit from a
// multiplexed active-low 7-segment bus, with a stability filter against scan ghosting.
//
// Ports:
//   clk, reset_n : rising-edge clock, async active-low reset
//   leds[7:0]    : active-low segments, bit7=dp, bits6:0=gfedcba
//   an[N-1:0]    : active-low digit enables (exactly one low = legal)
//   clr          : synchronous clear of all captured digits
//   digits       : captured hex per digit, digit i at [4i+3:4i]
//   dps          : captured decimal point per digit (1 = lit)
//   valid        : digit holds a committed legal glyph
//   err          : last commit for the digit was an unknown pattern
//   upd, upd_idx : one-cycle commit pulse and index of the committed digit
module seg7_readback_decoder #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [7:0]              leds,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    clr,
    output logic [4*NUM_DIGITS-1:0] digits,
    output logic [NUM_DIGITS-1:0]   dps,
    output logic [NUM_DIGITS-1:0]   valid,
    output logic [NUM_DIGITS-1:0]   err,
    output logic                    upd,
    output logic [2:0]              upd_idx
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_TRACK = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam int SW = NUM_DIGITS + 8;

    logic [1:0]              state_q, state_d;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [SW-1:0]           smp_q, smp_d;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0]   dps_q, valid_q, err_q;
    logic                    upd_q;
    logic [2:0]              upd_idx_q;

    logic [6:0] pat;
    logic       dp_in;
    logic       legal;
    logic       same;
    logic       known;
    logic       blank;
    logic [3:0] val;
    logic [2:0] idx;
    logic       commit;

    assign smp_d = {an, leds};
    assign pat   = ~leds[6:0];
    assign dp_in = ~leds[7];
    assign legal = ($countones(~an) == 1);
    // The sample register holds the previous edge's bus, so "same" compares
    // the incoming sample against the one taken one edge earlier.
    assign same  = (smp_d == smp_q);
    assign blank = (pat == 7'h00);

    always_comb begin
        idx = 3'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an[i]) idx = 3'(i);
        end
    end

    always_comb begin
        known = 1'b1;
        val   = 4'h0;
        case (pat)
            7'h3F: val = 4'h0;
            7'h06: val = 4'h1;
            7'h5B: val = 4'h2;
            7'h4F: val = 4'h3;
            7'h66: val = 4'h4;
            7'h6D: val = 4'h5;
            7'h7D: val = 4'h6;
            7'h07: val = 4'h7;
            7'h7F: val = 4'h8;
            7'h6F: val = 4'h9;
            7'h77: val = 4'hA;
            7'h7C: val = 4'hB;
            7'h58: val = 4'hC;
            7'h5E: val = 4'hD;
            7'h79: val = 4'hE;
            7'h71: val = 4'hF;
            default: known = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (legal) begin
                    state_d = S_TRACK;
                    cnt_d   = CNT_ONE;
                end
            end
            S_TRACK: begin
                if (!legal) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (same) begin
                    if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                end else begin
                    cnt_d = CNT_ONE;
                end
            end
            S_HOLD: begin
                if (!legal) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (!same) begin
                    state_d = S_TRACK;
                    cnt_d   = CNT_ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
        // Reaching the threshold commits on this same edge, which also
        // covers the single-cycle case straight out of IDLE or HOLD.
        if (state_d == S_TRACK && cnt_d == CNT_MAX) begin
            commit  = 1'b1;
            state_d = S_HOLD;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            smp_q     <= '0;
            digits_q  <= '0;
            dps_q     <= '0;
            valid_q   <= '0;
            err_q     <= '0;
            upd_q     <= 1'b0;
            upd_idx_q <= 3'd0;
        end else begin
            smp_q <= smp_d;
            upd_q <= 1'b0;
            if (clr) begin
                state_q  <= S_IDLE;
                cnt_q    <= '0;
                digits_q <= '0;
                dps_q    <= '0;
                valid_q  <= '0;
                err_q    <= '0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                if (commit) begin
                    upd_q     <= 1'b1;
                    upd_idx_q <= idx;
                end
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (commit && !an[i]) begin
                        dps_q[i] <= dp_in;
                        if (known) begin
                            digits_q[4*i +: 4] <= val;
                            valid_q[i]         <= 1'b1;
                            err_q[i]           <= 1'b0;
                        end else begin
                            valid_q[i] <= 1'b0;
                            err_q[i]   <= !blank;
                        end
                    end
                end
            end
        end
    end

    assign digits  = digits_q;
    assign dps     = dps_q;
    assign valid   = valid_q;
    assign err     = err_q;
    assign upd     = upd_q;
    assign upd_idx = upd_idx_q;

endmodule

// File: tb/tb_seg7_readback_decoder.sv
// Scoreboard bench for seg7_readback_decoder (4 digits, 4 stable cycles).
// Expected commits are queued at drive time and matched on each upd pulse.
module tb_seg7_readback_decoder;

    logic        clk;
    logic        reset_n;
    logic [7:0]  leds;
    logic [3:0]  an;
    logic        clr;
    logic [15:0] digits;
    logic [3:0]  dps;
    logic [3:0]  valid;
    logic [3:0]  err;
    logic        upd;
    logic [2:0]  upd_idx;

    seg7_readback_decoder #(
        .NUM_DIGITS(4),
        .STABLE_CYCLES(4)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .leds(leds),
        .an(an),
        .clr(clr),
        .digits(digits),
        .dps(dps),
        .valid(valid),
        .err(err),
        .upd(upd),
        .upd_idx(upd_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]  idx;
        logic [15:0] dig;
        logic [3:0]  dp;
        logic [3:0]  vl;
        logic [3:0]  er;
    } exp_t;

    exp_t sbq[$];

    int total = 0;
    int bad   = 0;

    logic [15:0] m_dig;
    logic [3:0]  m_dp, m_val, m_err;

    logic [6:0] glyph [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h58, 7'h5E, 7'h79, 7'h71
    };

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_dig = '0;
        m_dp  = '0;
        m_val = '0;
        m_err = '0;
    endtask

    task automatic model_commit(input logic [3:0] a, input logic [7:0] l);
        int    i;
        int    v;
        exp_t  e;
        logic [6:0] p;
        i = 0;
        for (int k = 0; k < 4; k++) if (!a[k]) i = k;
        p = ~l[6:0];
        v = -1;
        for (int k = 0; k < 16; k++) if (glyph[k] == p) v = k;
        m_dp[i] = ~l[7];
        if (v >= 0) begin
            m_dig[i*4 +: 4] = 4'(v);
            m_val[i] = 1'b1;
            m_err[i] = 1'b0;
        end else begin
            m_val[i] = 1'b0;
            m_err[i] = (p != 7'h00);
        end
        e.idx = 3'(i);
        e.dig = m_dig;
        e.dp  = m_dp;
        e.vl  = m_val;
        e.er  = m_err;
        sbq.push_back(e);
    endtask

    task automatic present(input logic [3:0] a, input logic [7:0] l,
                           input int n, input bit c);
        an   = a;
        leds = l;
        if (c) model_commit(a, l);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic settle(input string tag);
        repeat (3) @(posedge clk);
        #1;
        chk(tag, sbq.size(), 0);
    endtask

    task automatic chk_state(input string tag);
        chk({tag, "_dig"}, digits, m_dig);
        chk({tag, "_dp"}, dps, m_dp);
        chk({tag, "_val"}, valid, m_val);
        chk({tag, "_err"}, err, m_err);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n && upd) begin
            if (sbq.size() == 0) begin
                chk("spurious_upd", {29'd0, upd_idx}, 32'hFFFF_FFFF);
            end else begin
                e = sbq.pop_front();
                chk("upd_idx", upd_idx, e.idx);
                chk("upd_dig", digits, e.dig);
                chk("upd_dp", dps, e.dp);
                chk("upd_val", valid, e.vl);
                chk("upd_err", err, e.er);
            end
        end
    end

    initial begin
        reset_n = 1'b0;
        an      = 4'hF;
        leds    = 8'hFF;
        clr     = 1'b0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;

        present(4'b0111, ~8'h7F, 4, 1);
        settle("pre_reset");
        present(4'b1110, ~8'h06, 2, 0);
        reset_n = 1'b0;
        #1;
        chk("rst_upd", upd, 0);
        chk("rst_dig", digits, 0);
        chk("rst_dp", dps, 0);
        chk("rst_val", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_idx", upd_idx, 0);
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        present(4'b1110, ~8'h06, 4, 1);
        settle("post_reset");

        present(4'b1110, ~8'h3F, 6, 1);
        present(4'b1101, ~8'h5B, 6, 1);
        present(4'b1011, ~8'h4F, 6, 1);
        present(4'b0111, ~8'hF1, 6, 1);
        settle("scan");
        chk("scan_dig", digits, 16'hF320);
        chk("scan_dp", dps, 4'b1000);
        chk("scan_val", valid, 4'hF);

        present(4'b1011, ~8'h66, 3, 0);
        present(4'b1011, ~8'h6D, 3, 0);
        chk("ghost_none", sbq.size(), 0);
        present(4'b1011, ~8'h6D, 1, 1);
        settle("ghost");
        chk("ghost_dig", digits, 16'hF520);

        present(4'b1100, ~8'h06, 10, 0);
        present(4'b1111, ~8'h06, 10, 0);
        settle("illegal");
        chk_state("illegal");

        present(4'b1101, ~8'h49, 4, 1);
        settle("unknown");
        chk("unk_err1", err[1], 1);
        chk("unk_val1", valid[1], 0);
        chk("unk_dig1", digits[7:4], 4'h2);
        present(4'b1101, 8'hFF, 4, 1);
        settle("blank");
        chk("blk_err1", err[1], 0);
        chk("blk_val1", valid[1], 0);
        chk_state("blank");

        present(4'b1110, ~8'h6F, 3, 0);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        model_clear();
        chk_state("clr");
        @(negedge clk);
        chk("clr_no_upd", upd, 0);
        @(posedge clk);
        #1;
        present(4'b1110, ~8'h6F, 3, 1);
        settle("reclr");
        chk_state("reclr");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seg7_readback_decoder.md
Name: seg7_readback_decoder

Overview:
- Listens on a multiplexed active-low 7-segment display bus and reconstructs the hex value, decimal point and validity of each digit.
- Sits beside the display driver path. Feeds self-check logic and the debug register file with what the display actually shows.
- Inverse of the hex-to-segment encoder, with stability filtering against ghosting during digit scan.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
STABLE_CYCLES, 4, consecutive identical samples required before a commit (>=1)

Ports:
clk  input  1  system clock, rising edge
reset_n  input  1  asynchronous active-low reset
leds  input  8  active-low segment bus, bit7=dp, bits6:0=gfedcba
an  input  NUM_DIGITS  active-low digit enables, one-hot-low when legal
clr  input  1  synchronous clear of all captured digits
digits  output  4*NUM_DIGITS  captured hex value, digit i at [4i+3:4i]
dps  output  NUM_DIGITS  captured decimal point per digit (1 = lit)
valid  output  NUM_DIGITS  digit holds a committed legal glyph
err  output  NUM_DIGITS  last commit for digit was an unknown pattern
upd  output  1  one-cycle pulse on every commit
upd_idx  output  3  index of the digit committed with upd

Behaviour:
- Reset (asynchronous, reset_n low): all outputs 0, FSM to IDLE, sample register and counter cleared. Assertion mid-operation aborts any pending commit immediately.
- Sampling:
  - {an, leds} are registered every edge.
  - Segment pattern p = ~leds[6:0]; dp = ~leds[7].
  - Sample is legal when exactly one bit of an is 0.
- Decode table, p in hex gfedcba active-high:
  - 3F->0, 06->1, 5B->2, 4F->3, 66->4, 6D->5, 7D->6, 07->7
  - 7F->8, 6F->9, 77->A, 7C->b, 58->c, 5E->d, 79->E, 71->F
  - 00 = blank.
  - Any other p = unknown.
- FSM:
  - IDLE: no legal sample. Go to TRACK on a legal sample, cnt=1.
  - TRACK: legal sample equal to the previous sample -> cnt+1. Legal but different -> cnt=1. Illegal -> IDLE, cnt=0. When cnt reaches STABLE_CYCLES -> commit, go to HOLD.
  - HOLD: no further commits while the sample stays identical. Legal change -> TRACK, cnt=1. Illegal -> IDLE.
  - STABLE_CYCLES=1: every legal new sample commits on the edge it is sampled.
- Commit latency: input stable from before edge k commits at edge k+STABLE_CYCLES-1. upd and upd_idx are valid in the cycle after that edge.
- Commit effects for digit i (the index of the low an bit):
  - Known glyph: digits[i]=value, dps[i]=dp, valid[i]=1, err[i]=0.
  - Blank: valid[i]=0, err[i]=0, dps[i]=dp, digits[i] unchanged.
  - Unknown: err[i]=1, valid[i]=0, dps[i]=dp, digits[i] unchanged.
  - Other digits are untouched.
- upd_idx holds its last value when upd is 0. It is 0 after reset.
- clr:
  - Clears digits, dps, valid and err; FSM to IDLE; cnt=0.
  - clr with a coincident commit: clr wins, no upd pulse.
- Counter saturates at STABLE_CYCLES and has no wrap-around.
- an bits >= NUM_DIGITS do not exist. Multiple low an bits or none = illegal.

Test Plan:
- Reset: hold reset_n=0 mid-TRACK with an=1110, leds=~8'h06 -> all outputs 0. Release and hold 4 edges -> upd at digit 0, digits[3:0]=1, valid[0]=1.
- Scan: STABLE_CYCLES=4, present an=1110/leds=~3F, then 1101/~5B, then 1011/~4F, then 0111/~F1 (dp+F), each for 6 cycles. Expect:
  - Four upd pulses with upd_idx 0,1,2,3.
  - digits=16'hF320, dps=4'b1000, valid=4'hF.
- Ghosting: change leds after 3 stable cycles (digit 2, ~66 then ~6D, each 3 cycles) -> no upd. Holding ~6D a 4th cycle -> commit 5, exactly one upd.
- Illegal enables: an=1100 or 1111 with a stable glyph for 10 cycles -> no upd, outputs unchanged.
- Unknown/blank:
  - Digit 1 with p=0x49 stable -> err[1]=1, valid[1]=0, digits[7:4] retains 2.
  - Then p=0x00 -> err[1]=0, valid[1]=0.
- clr collision: assert clr on the commit edge -> no upd, all digit outputs 0, FSM IDLE. The same stable input then recommits after 4 edges.
